spi_shift_fifo: RTL and testbench

Parametrised shift-register FIFO for the SPI IP core's TX/RX data paths. It tracks occupancy and also stores data words. Entry 0 is always the head, and its data is presented with first-word fall-through. Beyond plain valid tracking it adds:
- simultaneous push+pull with data
- occupancy count and programmable almost-full/almost-empty flags
- flush
- sticky overflow/underflow error flags

---
 rtl/spi_shift_fifo.sv | 138 +++++++++++++
 tb/tb_spi_shift_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_shift_fifo.sv
// Shift-register FIFO for the SPI TX/RX data paths: entry 0 is the head (first-word
// fall-through), with occupancy, almost-full/empty thresholds, flush and sticky errors.
module spi_shift_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_THR  = DEPTH - 2,
    parameter int AEMPTY_THR = 1
) (
    input  logic                       iclk,
    input  logic                       irst,
    input  logic                       iflush,
    input  logic                       ipush,
    input  logic [WIDTH-1:0]           idata,
    input  logic                       ipull,
    input  logic                       iclr_err,
    output logic [WIDTH-1:0]           odata,
    output logic                       ovalid,
    output logic                       oempty,
    output logic                       ofull,
    output logic                       oalmost_full,
    output logic                       oalmost_empty,
    output logic [$clog2(DEPTH+1)-1:0] ocount,
    output logic                       ooverflow,
    output logic                       ounderflow
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] mem_s [DEPTH];
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_s;
    logic             overflow_r;
    logic             overflow_s;
    logic             underflow_r;
    logic             underflow_s;

    // Next-state computation: flush, push, pull and error-flag updates.
    always_comb begin
        mem_s       = mem_r;
        count_s     = count_r;
        overflow_s  = overflow_r;
        underflow_s = underflow_r;
        // Clear first so that a same-cycle error event below wins.
        if (iclr_err) begin
            overflow_s  = 1'b0;
            underflow_s = 1'b0;
        end else begin
            overflow_s  = overflow_r;
            underflow_s = underflow_r;
        end
        if (iflush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_s[i] = {WIDTH{1'b0}};
            end
            count_s = {CW{1'b0}};
        end else begin
            case ({ipull, ipush})
                2'b01: begin
                    if (count_r < DEPTH_C) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (count_r == CW'(i)) begin
                                mem_s[i] = idata;
                            end else begin
                                mem_s[i] = mem_r[i];
                            end
                        end
                        count_s = count_r + ONE_C;
                    end else begin
                        overflow_s = 1'b1;
                    end
                end
                2'b10: begin
                    if (count_r != {CW{1'b0}}) begin
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            mem_s[i] = mem_r[i+1];
                        end
                        mem_s[DEPTH-1] = {WIDTH{1'b0}};
                        count_s = count_r - ONE_C;
                    end else begin
                        underflow_s = 1'b1;
                    end
                end
                2'b11: begin
                    if (count_r != {CW{1'b0}}) begin
                        // Shift the head out and land the new word in the slot the tail vacated.
                        for (int i = 0; i < DEPTH; i++) begin
                            if (count_r - ONE_C == CW'(i)) begin
                                mem_s[i] = idata;
                            end else if (i < DEPTH - 1) begin
                                mem_s[i] = mem_r[i+1];
                            end else begin
                                mem_s[i] = {WIDTH{1'b0}};
                            end
                        end
                    end else begin
                        mem_s[0]    = idata;
                        count_s     = ONE_C;
                        underflow_s = 1'b1;
                    end
                end
                default: begin
                    count_s = count_r;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge iclk) begin
        if (irst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            mem_r       <= mem_s;
            count_r     <= count_s;
            overflow_r  <= overflow_s;
            underflow_r <= underflow_s;
        end
    end

    assign odata         = mem_r[0];
    assign ocount        = count_r;
    assign oempty        = (count_r == {CW{1'b0}});
    assign ovalid        = ~oempty;
    assign ofull         = (count_r == DEPTH_C);
    assign oalmost_full  = (count_r >= AFULL_C);
    assign oalmost_empty = (count_r <= AEMPTY_C);
    assign ooverflow     = overflow_r;
    assign ounderflow    = underflow_r;
endmodule

// File: tb/tb_spi_shift_fifo.sv
// Self-checking bench for spi_shift_fifo: directed plan steps followed by random
// traffic, all checked against a queue-based reference model.
module tb_spi_shift_fifo;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);
    localparam int AF = D - 2;
    localparam int AE = 1;

    logic          iclk = 1'b0;
    logic          irst = 1'b0;
    logic          iflush = 1'b0;
    logic          ipush = 1'b0;
    logic [W-1:0]  idata = '0;
    logic          ipull = 1'b0;
    logic          iclr_err = 1'b0;
    logic [W-1:0]  odata;
    logic          ovalid, oempty, ofull, oalmost_full, oalmost_empty;
    logic [CW-1:0] ocount;
    logic          ooverflow, ounderflow;

    spi_shift_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_THR(AF), .AEMPTY_THR(AE)) dut (
        .iclk(iclk), .irst(irst), .iflush(iflush), .ipush(ipush), .idata(idata),
        .ipull(ipull), .iclr_err(iclr_err), .odata(odata), .ovalid(ovalid),
        .oempty(oempty), .ofull(ofull), .oalmost_full(oalmost_full),
        .oalmost_empty(oalmost_empty), .ocount(ocount), .ooverflow(ooverflow),
        .ounderflow(ounderflow)
    );

    always #5 iclk = ~iclk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue holding the stored words in order, plus error flags.
    logic [W-1:0] q[$];
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic rst, fl, pu, pl, clr, input logic [W-1:0] d);
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            if (fl) begin
                q.delete();
            end else if (pu && !pl) begin
                if (q.size() < D) q.push_back(d);
                else m_ovf = 1'b1;
            end else if (pl && !pu) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_udf = 1'b1;
            end else if (pl && pu) begin
                if (q.size() > 0) begin
                    void'(q.pop_front());
                    q.push_back(d);
                end else begin
                    q.push_back(d);
                    m_udf = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = q.size();
        chk({ctx, "/count"}, 32'(ocount), 32'(n));
        chk({ctx, "/odata"}, 32'(odata), (n > 0) ? 32'(q[0]) : 32'd0);
        chk({ctx, "/empty"}, 32'(oempty), 32'(n == 0));
        chk({ctx, "/valid"}, 32'(ovalid), 32'(n != 0));
        chk({ctx, "/full"}, 32'(ofull), 32'(n == D));
        chk({ctx, "/afull"}, 32'(oalmost_full), 32'(n >= AF));
        chk({ctx, "/aempty"}, 32'(oalmost_empty), 32'(n <= AE));
        chk({ctx, "/ovf"}, 32'(ooverflow), 32'(m_ovf));
        chk({ctx, "/udf"}, 32'(ounderflow), 32'(m_udf));
    endtask

    task automatic step(input string ctx, input logic rst, fl, pu, pl, clr, input logic [W-1:0] d);
        irst = rst; iflush = fl; ipush = pu; ipull = pl; iclr_err = clr; idata = d;
        @(posedge iclk);
        model(rst, fl, pu, pl, clr, d);
        #1;
        irst = 1'b0; iflush = 1'b0; ipush = 1'b0; ipull = 1'b0; iclr_err = 1'b0;
        check_all(ctx);
    endtask

    initial begin
        logic [W-1:0] v;
        int bias;
        // 1: reset then idle
        step("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("reset_aempty", 32'(oalmost_empty), 32'd1);
        step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // 2: fill 0x01..0x10, then overflow
        for (int i = 1; i <= D; i++) begin
            step("fill", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(i));
            if (i == 1) chk("first_word", 32'(odata), 32'h01);
            if (i == AF) chk("afull_at_14", 32'(oalmost_full), 32'd1);
        end
        chk("full_flag", 32'(ofull), 32'd1);
        step("ovf_push", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA);
        chk("ovf_set", 32'(ooverflow), 32'd1);

        // 3: drain 16, then underflow, then clear
        for (int i = 1; i <= D; i++) begin
            chk("drain_head", 32'(odata), 32'(i));
            step("drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        end
        step("udf_pull", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("udf_set", 32'(ounderflow), 32'd1);
        step("clr_err", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_ovf", 32'(ooverflow), 32'd0);

        // 4: simultaneous push+pull at count 3, when full, when empty
        step("p11", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        step("p22", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22);
        step("p33", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33);
        step("pp44", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h44);
        chk("pp_head", 32'(odata), 32'h22);
        chk("pp_count", 32'(ocount), 32'd3);
        for (int i = 0; i < D - 3; i++) step("refill", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(8'h60 + i));
        step("pp_full", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h99);
        chk("pp_full_count", 32'(ocount), 32'd16);
        chk("pp_full_noovf", 32'(ooverflow), 32'd0);
        for (int i = 0; i < D; i++) step("order", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        step("pp_empty", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
        chk("pp_empty_head", 32'(odata), 32'h55);
        chk("pp_empty_udf", 32'(ounderflow), 32'd1);

        // 5: flush with push at count 5, errors held
        step("pull55", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step("to5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(8'hB0 + i));
        step("flush", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
        chk("flush_odata", 32'(odata), 32'h00);
        chk("flush_udf_held", 32'(ounderflow), 32'd1);

        // 6: reset with push at count 7, then clear racing an overflow
        for (int i = 0; i < 7; i++) step("to7", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(8'hC0 + i));
        step("rst_push", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
        chk("rst_count", 32'(ocount), 32'd0);
        for (int i = 0; i < D; i++) step("to_full", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(8'hD0 + i));
        step("clr_vs_ovf", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12);
        chk("set_wins", 32'(ooverflow), 32'd1);

        // Random traffic with a push/pull bias that swings between filling and draining.
        bias = 70;
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic rst, fl, pu, pl, clr;
            if (c % 150 == 0) bias = (bias == 70) ? 30 : 70;
            r   = $urandom_range(0, 199);
            rst = (r == 0);
            fl  = (r >= 1 && r <= 3);
            clr = ($urandom_range(0, 19) == 0);
            pu  = ($urandom_range(0, 99) < bias);
            pl  = ($urandom_range(0, 99) < (100 - bias));
            v   = W'($urandom);
            step("rand", rst, fl, pu, pl, clr, v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
